// File: rtl/array_mul_pkg.sv
// Default operand and product widths for the array multiplier.
package array_mul_pkg;

    localparam int unsigned M_W = 4;
    localparam int unsigned Q_W = 4;
    localparam int unsigned P_W = M_W + Q_W;

endpackage : array_mul_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the multiplier reduction array.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule : full_adder

// File: rtl/array_multiplier.sv
// Registered unsigned ripple-array multiplier: input registers, AND-plane,
// (WIDTHQ-1) x WIDTHM full-adder grid, output register. Latency 2 edges.
module array_multiplier
    import array_mul_pkg::*;
#(
    parameter int unsigned WIDTHM = M_W,
    parameter int unsigned WIDTHQ = Q_W,
    parameter int unsigned WIDTHP = WIDTHM + WIDTHQ
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [WIDTHM-1:0] m_i,
    input  logic [WIDTHQ-1:0] q_i,
    output logic [WIDTHP-1:0] product_o
);

    logic [WIDTHM-1:0] m_r, m_d;
    logic [WIDTHQ-1:0] q_r, q_d;
    logic [WIDTHP-1:0] product_q, product_d;

    logic [WIDTHM-1:0] pp  [WIDTHQ];
    // acc[r] = {row carry-out, row sums}; acc[0] is the bare first partial product
    logic [WIDTHM:0]   acc [WIDTHQ];
    logic [WIDTHM-1:0] cy  [WIDTHQ-1];

    always_comb begin
        m_d = m_i;
        q_d = q_i;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_r <= '0;
            q_r <= '0;
        end else begin
            m_r <= m_d;
            q_r <= q_d;
        end
    end

    always_comb begin
        pp = '{default: '0};
        for (int unsigned j = 0; j < WIDTHQ; j++) begin
            for (int unsigned i = 0; i < WIDTHM; i++) begin
                pp[j][i] = m_r[i] & q_r[j];
            end
        end
    end

    assign acc[0] = {1'b0, pp[0]};

    // Row r adds pp[r] to the previous row shifted right by one; its LSB retires
    // as product bit r, the rest (plus carry-out) feeds the next row.
    for (genvar r = 1; r < WIDTHQ; r++) begin : g_row
        for (genvar i = 0; i < WIDTHM; i++) begin : g_cell
            if (i == 0) begin : g_half
                full_adder u_fa (
                    .a    (pp[r][i]),
                    .b    (acc[r-1][i+1]),
                    .cin  (1'b0),
                    .sum  (acc[r][i]),
                    .cout (cy[r-1][i])
                );
            end else begin : g_full
                full_adder u_fa (
                    .a    (pp[r][i]),
                    .b    (acc[r-1][i+1]),
                    .cin  (cy[r-1][i-1]),
                    .sum  (acc[r][i]),
                    .cout (cy[r-1][i])
                );
            end
        end
        assign acc[r][WIDTHM] = cy[r-1][WIDTHM-1];
    end

    always_comb begin
        product_d = '0;
        for (int unsigned j = 0; j < WIDTHQ; j++) begin
            product_d[j] = acc[j][0];
        end
        for (int unsigned i = 1; i <= WIDTHM; i++) begin
            product_d[WIDTHQ-1+i] = acc[WIDTHQ-1][i];
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            product_q <= '0;
        end else begin
            product_q <= product_d;
        end
    end

    assign product_o = product_q;

endmodule : array_multiplier

// File: tb/tb_array_multiplier.sv
// Self-checking bench for array_multiplier: product = m*q two edges after capture.
module tb_array_multiplier;

    localparam int unsigned WM = 4;
    localparam int unsigned WQ = 4;
    localparam int unsigned WP = 8;

    logic          clk;
    logic          rstN;
    logic [WM-1:0] m_i;
    logic [WQ-1:0] q_i;
    logic [WP-1:0] product_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 0;
    bit rst_hit  = 0;

    array_multiplier #(
        .WIDTHM (WM),
        .WIDTHQ (WQ),
        .WIDTHP (WP)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .m_i       (m_i),
        .q_i       (q_i),
        .product_o (product_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Any reset activity wipes whatever operands are in flight.
    always @(negedge rstN) rst_hit = 1;

    // Reference model: the value presented after an edge is the product of the
    // operands sampled at the previous edge, unless reset intervened.
    initial begin : compare
        int unsigned  pend;
        logic [WP-1:0] exp_now;
        pend = 0;
        forever begin
            @(posedge clk);
            if (!rstN || rst_hit) exp_now = '0;
            else                  exp_now = pend[WP-1:0];
            pend    = rstN ? (int'(m_i) * int'(q_i)) : 0;
            rst_hit = !rstN;
            #1;
            if (armed) begin
                n_checks++;
                if (product_o !== exp_now) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t product_o=%0d expected=%0d", $time, product_o, exp_now);
                end
            end
        end
    end

    task automatic check_lit(input string name, input logic [WP-1:0] exp);
        n_checks++;
        if (product_o !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t product_o=%0d expected=%0d", name, $time, product_o, exp);
        end
    endtask

    task automatic drive(input int unsigned m, input int unsigned q);
        @(negedge clk);
        m_i = m[WM-1:0];
        q_i = q[WQ-1:0];
    endtask

    task automatic wait_out;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    int cm [5] = '{0, 15, 15, 1, 8};
    int cq [5] = '{15, 0, 15, 13, 8};
    int ce [5] = '{0, 0, 225, 13, 64};

    initial begin
        rstN = 1;
        m_i  = '0;
        q_i  = '0;

        // Reset window 20..30 ns; output must read zero asynchronously.
        #20;
        armed = 1;
        rstN  = 0;
        #1 check_lit("reset_async", 8'd0);
        #9 rstN = 1;

        // Directed 6*14 held, then verify stability.
        drive(6, 14);
        wait_out();
        check_lit("directed_6x14", 8'd84);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check_lit("directed_hold", 8'd84);
        end

        for (int k = 0; k < 5; k++) begin
            drive(cm[k], cq[k]);
            wait_out();
            check_lit("corner", ce[k][WP-1:0]);
        end

        // Exhaustive back-to-back stream; the compare process checks each cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(a, b);
            end
        end

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 15), $urandom_range(0, 15));
        end

        // Mid-stream reset during a 9*7 stream.
        drive(9, 7);
        wait_out();
        check_lit("stream_9x7", 8'd63);
        @(negedge clk);
        #3 rstN = 0;
        #1 check_lit("midstream_async_clear", 8'd0);
        @(negedge clk);
        rstN = 1;
        @(posedge clk);
        #1 check_lit("post_release_edge1", 8'd0);
        @(posedge clk);
        #1 check_lit("post_release_edge2", 8'd63);

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_array_multiplier
